// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter: round-robin arbiter sequencing S/R pulses into one shared SR latch
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_req         per-requester level request
//   i_op          per-requester operation (1=set, 0=reset), sampled at acceptance
//   o_s, o_r      registered latch set/reset drives, never high together
//   i_q, i_qn     latch readback, only looked at in the check cycle
//   o_gnt         one-hot grant held for the whole operation
//   o_busy        operation in progress
//   o_done        one-cycle pulse in the check cycle
//   o_err         readback mismatch, qualified by o_done
module sr_latch_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_op,
    output logic               o_s,
    output logic               o_r,
    input  logic               i_q,
    input  logic               i_qn,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);
    localparam int CNT_MAX = PULSE_CYCLES > SETTLE_CYCLES ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_idx;
    logic               r_op;
    logic               r_s;
    logic               r_r;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_busy;
    logic               r_done;
    logic [PW-1:0]      w_idx;
    logic [PW-1:0]      w_pos;
    logic               w_op;

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        w_idx = '0;
        w_pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = PW'((int'(r_ptr) + k) % NUM_REQ);
            w_idx = i_req[w_pos] ? w_pos : w_idx;
        end
    end

    assign w_op = i_op[w_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_op    <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_state <= DRIVE;
                        r_idx   <= w_idx;
                        r_op    <= w_op;
                        r_s     <= w_op;
                        r_r     <= ~w_op;
                        r_gnt   <= NUM_REQ'(1) << w_idx;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                DRIVE: begin
                    if (r_cnt == CW'(PULSE_CYCLES - 1)) begin
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= SETTLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    r_done  <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_s    = r_s;
    assign o_r    = r_r;
    assign o_gnt  = r_gnt;
    assign o_busy = r_busy;
    assign o_done = r_done;
    // Readback is compared live in the check cycle so Q/Qn elsewhere never matter.
    assign o_err  = r_done & ((i_q != r_op) | (i_qn != ~r_op));
endmodule

// File: tb/tb_sr_latch_arbiter.sv
// tb_sr_latch_arbiter: directed and random checks of sr_latch_arbiter against an operation-level model
module tb_sr_latch_arbiter;
    localparam int N = 4, P = 2, ST = 1, OPLEN = P + ST + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] op = '0;
    logic         s, r, q, qn, busy, done, err;
    logic [N-1:0] gnt;
    logic         lat = 1'b0;
    int           fault = 0;
    int           total = 0;
    int           bad = 0;
    int           m_ptr = 0;

    always #5 clk = ~clk;

    sr_latch_arbiter #(.NUM_REQ(N), .PULSE_CYCLES(P), .SETTLE_CYCLES(ST)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_op(op), .o_s(s), .o_r(r),
        .i_q(q), .i_qn(qn), .o_gnt(gnt), .o_busy(busy), .o_done(done), .o_err(err)
    );

    // External SR latch; fault 1 = Q stuck at 0, fault 2 = Qn follows Q.
    always @(posedge clk) if (s) lat <= 1'b1; else if (r) lat <= 1'b0;
    assign q  = (fault == 1) ? 1'b0 : lat;
    assign qn = (fault == 2) ? q : ~q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rq, input int ptr);
        for (int k = 0; k < N; k++) if (rq[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk(tag, {gnt, busy, s, r, done, err}, '0);
    endtask

    // Starts one cycle before the IDLE cycle; returns at the negedge of the CHECK cycle.
    task automatic run_op(input logic [N-1:0] rq, input logic [N-1:0] o, input bit scramble);
        int  idx;
        bit  eop, eerr;
        @(negedge clk);
        chk_idle("pre_idle");
        req  = rq;
        op   = o;
        idx  = pick(rq, m_ptr);
        eop  = o[idx];
        eerr = (fault == 2) || (fault == 1 && eop);
        for (int c = 1; c <= OPLEN; c++) begin
            @(negedge clk);
            chk("gnt", 32'(gnt), 32'(1) << idx);
            chk("busy", 32'(busy), 1);
            chk("s", 32'(s), 32'((c <= P) && eop));
            chk("r", 32'(r), 32'((c <= P) && !eop));
            chk("s_and_r", 32'(s & r), 0);
            chk("done", 32'(done), 32'(c == OPLEN));
            chk("err", 32'(err), 32'((c == OPLEN) && eerr));
            if (scramble && c == 1) begin
                req = N'($urandom);
                op  = N'($urandom);
            end
        end
        req   = '0;
        m_ptr = (idx + 1) % N;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        run_op(4'b0001, 4'b0001, 0);
        @(negedge clk);
        chk_idle("t1_idle_after");
        repeat (5) run_op(4'b1111, 4'b0101, 0);
        fault = 1;
        run_op(4'b0100, 4'b0100, 0);
        run_op(4'b1000, 4'b0000, 0);
        fault = 2;
        run_op(4'b0001, 4'b0000, 0);
        fault = 0;
        run_op(4'b0100, 4'b0000, 0);
        run_op(4'b1001, 4'b1000, 0);
        run_op(4'b1001, 4'b0001, 0);
        @(negedge clk);
        req = 4'b0100;
        op  = 4'b0100;
        @(negedge clk);
        chk("rst_pre_s", 32'(s), 1);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk_idle("rst_mid_drive");
        rst   = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        chk_idle("rst_after");
        run_op(4'b1110, 4'b0000, 0);
        repeat (4) run_op(N'($urandom_range(1, 15)), N'($urandom), 1);
        req = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_idle("idle20");
        end
        for (int i = 0; i < 40; i++) begin
            fault = $urandom_range(0, 5);
            if (fault > 2) fault = 0;
            run_op(N'($urandom_range(1, 15)), N'($urandom), 1'($urandom));
        end
        fault = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
